// File: rtl/alu_share_ctrl.sv
// Round-robin front end that lets two command sources share one external 4-bit ALU.
// Operands are registered toward the ALU, and the result is captured after a settle delay and returned on a valid/ready channel.
module alu_share_ctrl #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [1:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [1:0] req1_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_r,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic       alu_c,
  input  logic       alu_v,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_r,
  output logic [3:0] rsp_flags,
  output logic       busy
);

  localparam int SettleEff = (SETTLE_CYCLES < 1)  ? 1  :
                             (SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES;
  localparam logic [3:0] CntLoad = 4'(SettleEff - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_e;

  state_e     state_q;
  logic       last_q;
  logic [3:0] cnt_q;
  logic [3:0] alu_a_q, alu_b_q;
  logic [1:0] alu_op_q;
  logic       rsp_valid_q, rsp_id_q, busy_q;
  logic [3:0] rsp_r_q, rsp_flags_q;
  logic       grant0, grant1;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    // Readies are held low while reset is asserted so no command looks accepted.
    if (state_q == IDLE && rst_n) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_q;
        grant1 = !last_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_r_q     <= '0;
      rsp_flags_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            alu_a_q  <= grant1 ? req1_a  : req0_a;
            alu_b_q  <= grant1 ? req1_b  : req0_b;
            alu_op_q <= grant1 ? req1_op : req0_op;
            rsp_id_q <= grant1;
            cnt_q    <= CntLoad;
            busy_q   <= 1'b1;
            state_q  <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == 4'd0) begin
            rsp_r_q     <= alu_r;
            rsp_flags_q <= {alu_z, alu_n, alu_c, alu_v};
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            last_q      <= rsp_id_q;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_r      = rsp_r_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: a delayed ALU model, a transaction-level reference, and directed plus random traffic.
// A second instance built with SETTLE_CYCLES=0 checks the single-cycle settle path.
`timescale 1ns/1ps
module tb_alu_share_ctrl;

  localparam int S = 3;

  typedef struct packed {
    logic       v;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ALU behaviour: returns {r, z, n, c, v}
  function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
    logic [3:0] r;
    logic       c, v;
    logic [4:0] d;
    logic [7:0] p;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'd0: r = a & b;
      2'd1: r = a ^ b;
      2'd2: begin
        d = {1'b0, a} - {1'b0, b};
        r = d[3:0];
        c = d[4];
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      default: begin
        p = a * b;
        r = p[3:0];
        c = |p[7:4];
      end
    endcase
    return {r, (r == 4'd0), r[3], c, v};
  endfunction

  // Main instance: SETTLE_CYCLES=3, ALU results lag their inputs by two clocks
  cmd_t       rq [2];
  logic       rsp_ready;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [3:0] alu_a, alu_b, rsp_r, rsp_flags;
  logic [1:0] alu_op;
  logic [7:0] p1, p2;

  always @(posedge clk) begin
    p1 <= alu_ref(alu_a, alu_b, alu_op);
    p2 <= p1;
  end

  alu_share_ctrl #(.SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(rq[0].v), .req0_ready(req0_ready),
    .req0_a(rq[0].a), .req0_b(rq[0].b), .req0_op(rq[0].op),
    .req1_valid(rq[1].v), .req1_ready(req1_ready),
    .req1_a(rq[1].a), .req1_b(rq[1].b), .req1_op(rq[1].op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(p2[7:4]), .alu_z(p2[3]), .alu_n(p2[2]), .alu_c(p2[1]), .alu_v(p2[0]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_r(rsp_r), .rsp_flags(rsp_flags), .busy(busy)
  );

  // Second instance: SETTLE_CYCLES=0 (behaves as 1), combinational ALU
  cmd_t       s_cmd;
  logic       s_rsp_ready;
  logic       s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_busy;
  logic [3:0] s_alu_a, s_alu_b, s_rsp_r, s_rsp_flags;
  logic [1:0] s_alu_op;
  logic [7:0] s_res;

  assign s_res = alu_ref(s_alu_a, s_alu_b, s_alu_op);

  alu_share_ctrl #(.SETTLE_CYCLES(0)) u_s0 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(s_cmd.v), .req0_ready(s_req0_ready),
    .req0_a(s_cmd.a), .req0_b(s_cmd.b), .req0_op(s_cmd.op),
    .req1_valid(1'b0), .req1_ready(s_req1_ready),
    .req1_a(4'h0), .req1_b(4'h0), .req1_op(2'h0),
    .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_op(s_alu_op),
    .alu_r(s_res[7:4]), .alu_z(s_res[3]), .alu_n(s_res[2]), .alu_c(s_res[1]), .alu_v(s_res[0]),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(s_rsp_id),
    .rsp_r(s_rsp_r), .rsp_flags(s_rsp_flags), .busy(s_busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding command, its response due S edges after accept
  bit   out_busy;
  bit   out_id;
  cmd_t out_cmd;
  cmd_t exp_alu;
  bit   last_id;
  int   cyc, due;
  bit   acc_prev [2];
  int   passed [2];
  int   gq [$];

  task automatic model_reset();
    out_busy = 0;
    out_id   = 0;
    out_cmd  = '0;
    exp_alu  = '0;
    last_id  = 1;
    cyc      = 0;
    due      = 0;
    acc_prev = '{0, 0};
    passed   = '{0, 0};
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_rsp_r"}, rsp_r, 0);
    check({tag, "_rsp_flags"}, rsp_flags, 0);
    check({tag, "_alu"}, {alu_a, alu_b, alu_op}, 0);
    check({tag, "_readies"}, {req0_ready, req1_ready}, 0);
    check({tag, "_s0_outs"}, {s_busy, s_rsp_valid, s_alu_a, s_req0_ready, s_req1_ready}, 0);
  endtask

  task automatic drive_random();
    for (int i = 0; i < 2; i++) begin
      if (rq[i].v && !acc_prev[i]) begin
        if ($urandom_range(0, 3) == 0) begin
          rq[i].a  = 4'($urandom);
          rq[i].b  = 4'($urandom);
          rq[i].op = 2'($urandom);
        end
      end else begin
        rq[i].v  = 1'($urandom_range(0, 1));
        rq[i].a  = 4'($urandom);
        rq[i].b  = 4'($urandom);
        rq[i].op = 2'($urandom);
      end
    end
    rsp_ready = ($urandom_range(0, 2) != 0);
  endtask

  // One clock: check registered outputs at negedge, optionally drive, check readies, advance the model
  task automatic step(input bit rnd);
    bit         e0, e1, rv, hs;
    logic [7:0] res;
    @(negedge clk);
    rv = out_busy && (cyc >= due);
    check("busy", busy, out_busy);
    check("rsp_valid", rsp_valid, rv);
    if (rv) begin
      res = alu_ref(out_cmd.a, out_cmd.b, out_cmd.op);
      check("rsp_id", rsp_id, out_id);
      check("rsp_r", rsp_r, res[7:4]);
      check("rsp_flags", rsp_flags, res[3:0]);
    end
    check("alu_a", alu_a, exp_alu.a);
    check("alu_b", alu_b, exp_alu.b);
    check("alu_op", alu_op, exp_alu.op);
    if (rnd) drive_random();
    #1;
    if (out_busy) begin
      e0 = 0;
      e1 = 0;
    end else if (rq[0].v && rq[1].v) begin
      e0 = last_id;
      e1 = !last_id;
    end else begin
      e0 = rq[0].v;
      e1 = rq[1].v;
    end
    check("req0_ready", req0_ready, e0);
    check("req1_ready", req1_ready, e1);
    for (int j = 0; j < 2; j++) begin
      if (!rq[j].v) passed[j] = 0;
    end
    if (req0_ready && rq[0].v) begin
      gq.push_back(0);
      passed[0] = 0;
      if (rq[1].v) begin
        passed[1]++;
        check("starve1", (passed[1] <= 1), 1);
      end
    end
    if (req1_ready && rq[1].v) begin
      gq.push_back(1);
      passed[1] = 0;
      if (rq[0].v) begin
        passed[0]++;
        check("starve0", (passed[0] <= 1), 1);
      end
    end
    hs = rv && rsp_ready;
    acc_prev[0] = e0 && rq[0].v;
    acc_prev[1] = e1 && rq[1].v;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) begin
      out_busy = 0;
      last_id  = out_id;
    end
    if (acc_prev[0] || acc_prev[1]) begin
      out_busy = 1;
      out_id   = acc_prev[1];
      out_cmd  = rq[out_id];
      exp_alu  = out_cmd;
      due      = cyc + S;
    end
  endtask

  initial begin
    logic [7:0] sres;
    rq          = '{'0, '0};
    rsp_ready   = 1'b0;
    s_cmd       = '0;
    s_rsp_ready = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_reset_zero("rst");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single request through the SETTLE_CYCLES=0 instance
    s_cmd = '{v: 1'b1, a: 4'hC, b: 4'hA, op: 2'd0};
    #1 check("s0_ready", s_req0_ready, 1);
    @(posedge clk);
    #1 s_cmd.v = 1'b0;
    check("s0_alu", {s_alu_a, s_alu_b, s_alu_op}, {4'hC, 4'hA, 2'd0});
    check("s0_rsp_valid_early", s_rsp_valid, 0);
    check("s0_busy", s_busy, 1);
    @(posedge clk);
    #1;
    sres = alu_ref(4'hC, 4'hA, 2'd0);
    check("s0_rsp_valid", s_rsp_valid, 1);
    check("s0_rsp_r", s_rsp_r, 4'h8);
    check("s0_rsp_id", s_rsp_id, 0);
    check("s0_rsp_flags", s_rsp_flags, sres[3:0]);
    s_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("s0_rsp_done", {s_rsp_valid, s_busy}, 0);
    check("s0_alu_hold", s_alu_a, 4'hC);
    s_rsp_ready = 1'b0;

    // Round-robin contention
    rq[0] = '{v: 1'b1, a: 4'd3, b: 4'd5, op: 2'd3};
    rq[1] = '{v: 1'b1, a: 4'd5, b: 4'd3, op: 2'd2};
    rsp_ready = 1'b1;
    gq.delete();
    for (int i = 0; i < 80 && gq.size() < 4; i++) step(0);
    check("rr_count", gq.size(), 4);
    for (int i = 0; i < gq.size() && i < 4; i++) check("rr_order", gq[i], i % 2);
    rq[0].v = 1'b0;
    rq[1].v = 1'b0;
    repeat (8) step(0);

    // Response backpressure with a payload change while req1 waits
    rsp_ready = 1'b0;
    rq[0] = '{v: 1'b1, a: 4'h2, b: 4'h9, op: 2'd1};
    step(0);
    rq[0].v = 1'b0;
    rq[1] = '{v: 1'b1, a: 4'h1, b: 4'h4, op: 2'd0};
    repeat (S) step(0);
    repeat (3) step(0);
    rq[1].a = 4'h7;
    repeat (3) step(0);
    rsp_ready = 1'b1;
    step(0);
    step(0);
    rq[1].v = 1'b0;
    check("pay_alu_a", alu_a, 4'h7);
    repeat (8) step(0);

    // Reset in the middle of SETTLE
    rq[0] = '{v: 1'b1, a: 4'h6, b: 4'h3, op: 2'd2};
    step(0);
    rq[0].v = 1'b0;
    step(0);
    #2 rst_n = 1'b0;
    rq[0] = '{v: 1'b1, a: 4'hB, b: 4'h1, op: 2'd1};
    rq[1] = '{v: 1'b1, a: 4'h4, b: 4'h4, op: 2'd3};
    #1 check_reset_zero("midrst");
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    gq.delete();
    step(0);
    check("rst_prio_n", gq.size(), 1);
    if (gq.size() > 0) check("rst_prio_id", gq[0], 0);

    // Randomised traffic
    repeat (1500) step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
Two-requester controller that shares one structural 4-bit ALU instance (A, B, Op -> R, Z, N, C, V) between independent command sources, e.g. front-panel switch logic and a host-link decoder. It arbitrates requests round-robin and drives registered operands and opcode to the ALU. After a programmable settle time it captures the result and flags, and returns them with the requester ID over a valid/ready response channel. The ALU itself is instantiated outside this block, at the same level.

Parameters:
SETTLE_CYCLES, 1, cycles ALU inputs are held stable before capture; legal 1..15, and a value of 0 is treated as 1.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has a command
req0_ready  out  1  requester 0 command accepted this cycle
req0_a  in  4  requester 0 operand A
req0_b  in  4  requester 0 operand B
req0_op  in  2  requester 0 opcode (0 AND, 1 XOR, 2 SUB, 3 MUL)
req1_valid  in  1  requester 1 has a command
req1_ready  out  1  requester 1 command accepted this cycle
req1_a  in  4  requester 1 operand A
req1_b  in  4  requester 1 operand B
req1_op  in  2  requester 1 opcode
alu_a  out  4  registered operand A to ALU
alu_b  out  4  registered operand B to ALU
alu_op  out  2  registered opcode to ALU
alu_r  in  4  ALU result
alu_z, alu_n, alu_c, alu_v  in  1 each  ALU flags
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that issued the command
rsp_r  out  4  captured result
rsp_flags  out  4  captured flags {Z,N,C,V}
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; round-robin pointer last=1, so req0 wins first; settle counter=0. Any in-flight transaction is dropped and no response is produced.
- FSM states: IDLE, SETTLE, RESP.
- IDLE, grant logic (combinational):
  - Only one valid: that requester is granted.
  - Both valid: the requester != last is granted.
  - reqX_ready = (state==IDLE) && granted X. Readies are never both high.
  - Ready may depend combinationally on valids. Valid must not depend on ready.
- IDLE, on accept edge (valid & ready):
  - Latch a, b, op into alu_a/alu_b/alu_op and the ID into rsp_id.
  - Load counter = SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - alu_a/b/op are held constant.
  - If counter==0: capture alu_r into rsp_r and {alu_z,alu_n,alu_c,alu_v} into rsp_flags; set rsp_valid=1; go to RESP. Otherwise decrement the counter.
- Latency: accept at edge k; rsp_valid rises at edge k+SETTLE_CYCLES.
- RESP:
  - rsp_valid, rsp_id, rsp_r and rsp_flags are held stable until rsp_ready=1.
  - On the handshake edge: rsp_valid=0, last=rsp_id, go to IDLE.
  - No request is accepted in RESP. The earliest next accept is the cycle after the response handshake.
- alu_a/b/op keep their last values after completion (not cleared) until the next accept.
- Requests are not buffered. A requester holds valid and its payload until it sees ready. Payload changes while not ready are ignored.
- rsp_ready asserted outside RESP has no effect.
- Starvation bound: a continuously valid requester is served within at most one other transaction.

Test Plan:
- Reset and single request. Hold rst_n=0 → all outputs 0. Release; req0 {A=4'hC, B=4'hA, op=0}, SETTLE_CYCLES=1 → req0_ready for 1 cycle; next edge alu_a=C, alu_b=A, alu_op=0; rsp_valid next edge with rsp_r=4'h8, rsp_id=0, rsp_flags matching the ALU at capture.
- Round-robin contention. req0 and req1 valid together for 4 transactions, rsp_ready=1 → grant order 0,1,0,1. Responses: req0 {3,5,op3} gives rsp_r=4'hF; req1 {5,3,op2} gives rsp_r=4'h2.
- Response backpressure. rsp_ready=0 for 6 cycles after rsp_valid, with new req1_valid pending → rsp fields stable; req1_ready stays 0 and busy=1. On rsp_ready=1, IDLE is reached and req1 is accepted the next cycle.
- Settle timing. SETTLE_CYCLES=3; bench ALU model changes alu_r 2 cycles after alu inputs change → captured rsp_r equals the settled value; rsp_valid rises exactly 3 edges after accept.
- Reset mid-operation. Assert rst_n=0 during SETTLE → immediate async clear. After release: no stale rsp_valid, and req0 has priority again.
- Payload change while waiting. req1_a changes from 4'h1 to 4'h7 while req1 is blocked by a busy transaction → the value present on the accept edge (4'h7) appears on alu_a.
